// File: rtl/loadable_up_counter_dec_n_if.sv
// Bus bundle for the two-digit loadable BCD up counter.
// The master side drives the tick, enable and load controls; the counter drives the digits and pulses.
interface loadable_up_counter_dec_n_if;
  logic       clk_time;
  logic       count_enable;
  logic       load_enable;
  logic [3:0] set_value1;
  logic [3:0] set_value10;
  logic [3:0] inc1;
  logic [3:0] inc10;
  logic       inc_clk;
  logic       load_error;

  modport master (
    output clk_time, count_enable, load_enable, set_value1, set_value10,
    input  inc1, inc10, inc_clk, load_error
  );

  modport slave (
    input  clk_time, count_enable, load_enable, set_value1, set_value10,
    output inc1, inc10, inc_clk, load_error
  );
endinterface

// File: rtl/loadable_up_counter_dec_n.sv
// Two-digit BCD up counter, modulus MODULUS (2..100), with synchronous parallel load,
// a one-cycle carry pulse on wrap and a one-cycle pulse on a rejected load value.
module loadable_up_counter_dec_n #(
  parameter int MODULUS = 60
) (
  input  logic                        clk,
  input  logic                        reset_n,
  loadable_up_counter_dec_n_if.slave  bus
);

  // Terminal count compared digit-wise, so MODULUS=100 terminates at 99.
  localparam logic [3:0] TERM_TENS = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] TERM_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] MOD_VAL   = 8'(MODULUS);

  logic [3:0] inc1_q, inc1_d;
  logic [3:0] inc10_q, inc10_d;
  logic       inc_clk_q, inc_clk_d;
  logic       load_error_q, load_error_d;

  logic [7:0] load_val;
  logic       load_ok;
  logic       tick;
  logic       at_term;

  // Wide enough for non-BCD digits (up to 165) so an illegal value cannot alias into range.
  assign load_val = ({4'd0, bus.set_value10} * 8'd10) + {4'd0, bus.set_value1};
  assign load_ok  = (bus.set_value1 <= 4'd9) && (bus.set_value10 <= 4'd9) && (load_val < MOD_VAL);
  assign tick     = bus.clk_time && bus.count_enable;
  assign at_term  = (inc10_q == TERM_TENS) && (inc1_q == TERM_ONES);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    inc1_d       = inc1_q;
    inc10_d      = inc10_q;
    inc_clk_d    = 1'b0;
    load_error_d = 1'b0;

    if (bus.load_enable) begin
      if (load_ok) begin
        inc1_d  = bus.set_value1;
        inc10_d = bus.set_value10;
      end else begin
        inc1_d       = 4'd0;
        inc10_d      = 4'd0;
        load_error_d = 1'b1;
      end
    end else if (tick) begin
      if (at_term) begin
        inc1_d    = 4'd0;
        inc10_d   = 4'd0;
        inc_clk_d = 1'b1;
      end else if (inc1_q == 4'd9) begin
        inc1_d  = 4'd0;
        inc10_d = inc10_q + 4'd1;
      end else begin
        inc1_d = inc1_q + 4'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inc1_q       <= 4'd0;
      inc10_q      <= 4'd0;
      inc_clk_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      inc1_q       <= inc1_d;
      inc10_q      <= inc10_d;
      inc_clk_q    <= inc_clk_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.inc1       = inc1_q;
  assign bus.inc10      = inc10_q;
  assign bus.inc_clk    = inc_clk_q;
  assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_loadable_up_counter_dec_n.sv
// Directed bench for loadable_up_counter_dec_n: three instances (modulus 60, 24, 100)
// sharing clock and reset, each feature exercised by its own task.
module tb_loadable_up_counter_dec_n;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  loadable_up_counter_dec_n_if if60 ();
  loadable_up_counter_dec_n_if if24 ();
  loadable_up_counter_dec_n_if if100 ();

  loadable_up_counter_dec_n #(.MODULUS(60))  dut60  (.clk(clk), .reset_n(reset_n), .bus(if60.slave));
  loadable_up_counter_dec_n #(.MODULUS(24))  dut24  (.clk(clk), .reset_n(reset_n), .bus(if24.slave));
  loadable_up_counter_dec_n #(.MODULUS(100)) dut100 (.clk(clk), .reset_n(reset_n), .bus(if100.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if60.clk_time  = 1'b0; if60.count_enable  = 1'b0; if60.load_enable  = 1'b0;
    if60.set_value1 = 4'd0; if60.set_value10 = 4'd0;
    if24.clk_time  = 1'b0; if24.count_enable  = 1'b0; if24.load_enable  = 1'b0;
    if24.set_value1 = 4'd0; if24.set_value10 = 4'd0;
    if100.clk_time = 1'b0; if100.count_enable = 1'b0; if100.load_enable = 1'b0;
    if100.set_value1 = 4'd0; if100.set_value10 = 4'd0;
  endtask

  task automatic load60(input logic [3:0] tens, input logic [3:0] ones);
    if60.load_enable = 1'b1; if60.set_value10 = tens; if60.set_value1 = ones;
    step();
    if60.load_enable = 1'b0;
  endtask

  task automatic tick60(input logic en);
    if60.clk_time = 1'b1; if60.count_enable = en;
    step();
    if60.clk_time = 1'b0; if60.count_enable = 1'b0;
  endtask

  task automatic load24(input logic [3:0] tens, input logic [3:0] ones);
    if24.load_enable = 1'b1; if24.set_value10 = tens; if24.set_value1 = ones;
    step();
    if24.load_enable = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset state of all instances.
    n_checks++;
    if ({if60.inc10, if60.inc1, if60.inc_clk, if60.load_error} !== 10'd0 ||
        {if24.inc10, if24.inc1, if24.inc_clk, if24.load_error} !== 10'd0 ||
        {if100.inc10, if100.inc1, if100.inc_clk, if100.load_error} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: m60=%h%h m24=%h%h m100=%h%h, required all 00 with pulses low",
               if60.inc10, if60.inc1, if24.inc10, if24.inc1, if100.inc10, if100.inc1);
    end
    reset_n = 1'b1;
    load60(4'd3, 4'd7);
    n_checks++;
    if (if60.inc10 !== 4'd3 || if60.inc1 !== 4'd7) begin
      n_fail++;
      $display("FAIL reset_preload: got %h%h, required 37", if60.inc10, if60.inc1);
    end
    // Leave a load_error pulse live on the 24 instance so reset hits it mid-pulse.
    if24.load_enable = 1'b1; if24.set_value10 = 4'd9; if24.set_value1 = 4'd9;
    step();
    if24.load_enable = 1'b0;
    n_checks++;
    if (if24.load_error !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prepulse: load_error=%b, required 1", if24.load_error);
    end
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (if60.inc10 !== 4'd0 || if60.inc1 !== 4'd0 || if60.inc_clk !== 1'b0 ||
        if24.load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %h%h inc_clk=%b load_error=%b, required 00 0 0",
               if60.inc10, if60.inc1, if60.inc_clk, if24.load_error);
    end
    #1;
    reset_n = 1'b1;
    tick60(1'b1);
    n_checks++;
    if (if60.inc10 !== 4'd0 || if60.inc1 !== 4'd1 || if60.inc_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_tick: got %h%h inc_clk=%b, required 01 0",
               if60.inc10, if60.inc1, if60.inc_clk);
    end
  endtask

  task automatic test_wrap();
    load60(4'd5, 4'd8);
    tick60(1'b1);
    n_checks++;
    if (if60.inc10 !== 4'd5 || if60.inc1 !== 4'd9 || if60.inc_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_59: got %h%h inc_clk=%b, required 59 0", if60.inc10, if60.inc1, if60.inc_clk);
    end
    tick60(1'b1);
    n_checks++;
    if (if60.inc10 !== 4'd0 || if60.inc1 !== 4'd0 || if60.inc_clk !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_00: got %h%h inc_clk=%b, required 00 1", if60.inc10, if60.inc1, if60.inc_clk);
    end
    tick60(1'b1);
    n_checks++;
    if (if60.inc10 !== 4'd0 || if60.inc1 !== 4'd1 || if60.inc_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_01: got %h%h inc_clk=%b, required 01 0", if60.inc10, if60.inc1, if60.inc_clk);
    end
  endtask

  task automatic test_roll_hold();
    load60(4'd0, 4'd9);
    tick60(1'b1);
    n_checks++;
    if (if60.inc10 !== 4'd1 || if60.inc1 !== 4'd0 || if60.inc_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL roll_10: got %h%h inc_clk=%b, required 10 0", if60.inc10, if60.inc1, if60.inc_clk);
    end
    tick60(1'b0);
    n_checks++;
    if (if60.inc10 !== 4'd1 || if60.inc1 !== 4'd0 || if60.inc_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_disabled: got %h%h inc_clk=%b, required 10 0", if60.inc10, if60.inc1, if60.inc_clk);
    end
  endtask

  task automatic test_collision();
    load60(4'd5, 4'd9);
    if60.load_enable = 1'b1; if60.set_value10 = 4'd2; if60.set_value1 = 4'd3;
    if60.clk_time = 1'b1; if60.count_enable = 1'b1;
    step();
    idle_all();
    n_checks++;
    if (if60.inc10 !== 4'd2 || if60.inc1 !== 4'd3 || if60.inc_clk !== 1'b0 || if60.load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL collision: got %h%h inc_clk=%b load_error=%b, required 23 0 0",
               if60.inc10, if60.inc1, if60.inc_clk, if60.load_error);
    end
  endtask

  task automatic test_invalid_load();
    load24(4'd1, 4'd5);
    load24(4'd2, 4'd7);
    n_checks++;
    if (if24.inc10 !== 4'd0 || if24.inc1 !== 4'd0 || if24.load_error !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_27: got %h%h load_error=%b, required 00 1", if24.inc10, if24.inc1, if24.load_error);
    end
    step();
    n_checks++;
    if (if24.load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_pulse_width: load_error=%b, required 0", if24.load_error);
    end
    load24(4'd1, 4'd5);
    load24(4'd1, 4'd12);
    n_checks++;
    if (if24.inc10 !== 4'd0 || if24.inc1 !== 4'd0 || if24.load_error !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_nonbcd: got %h%h load_error=%b, required 00 1", if24.inc10, if24.inc1, if24.load_error);
    end
    load24(4'd2, 4'd3);
    n_checks++;
    if (if24.inc10 !== 4'd2 || if24.inc1 !== 4'd3 || if24.load_error !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_23: got %h%h load_error=%b, required 23 0", if24.inc10, if24.inc1, if24.load_error);
    end
    if24.clk_time = 1'b1; if24.count_enable = 1'b1;
    step();
    idle_all();
    n_checks++;
    if (if24.inc10 !== 4'd0 || if24.inc1 !== 4'd0 || if24.inc_clk !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_24: got %h%h inc_clk=%b, required 00 1", if24.inc10, if24.inc1, if24.inc_clk);
    end
  endtask

  task automatic test_back_to_back_mod100();
    int pulses;
    int first_pulse;
    int second_pulse;
    int exp_val;
    pulses       = 0;
    first_pulse  = -1;
    second_pulse = -1;
    if100.clk_time = 1'b1; if100.count_enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      exp_val = (i + 1) % 100;
      n_checks++;
      if (if100.inc1 > 4'd9 || if100.inc10 > 4'd9 ||
          if100.inc10 !== 4'(exp_val / 10) || if100.inc1 !== 4'(exp_val % 10) ||
          if100.inc_clk !== (exp_val == 0)) begin
        n_fail++;
        $display("FAIL m100_cycle%0d: got %h%h inc_clk=%b, required %0d%0d %0d",
                 i, if100.inc10, if100.inc1, if100.inc_clk, exp_val / 10, exp_val % 10, exp_val == 0);
      end
      if (if100.inc_clk === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
        else if (second_pulse < 0) second_pulse = i;
      end
    end
    idle_all();
    n_checks++;
    if (pulses != 2 || (second_pulse - first_pulse) != 100) begin
      n_fail++;
      $display("FAIL m100_pulses: got %0d pulses spacing %0d, required 2 pulses spacing 100",
               pulses, second_pulse - first_pulse);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    idle_all();
    repeat (2) step();
    test_reset();
    test_wrap();
    test_roll_hold();
    test_collision();
    test_invalid_load();
    test_back_to_back_mod100();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loadable_up_counter_dec_n.md
# loadable_up_counter_dec_n

Two-digit BCD up counter with synchronous parallel load and a one-cycle carry pulse. It is the count-up counterpart of the watch's loadable BCD down counters, and it feeds the stopwatch and clock-set paths. Instances are cascaded by driving the next stage's `clk_time` from this stage's `inc_clk`. The modulus is a parameter, so one module covers the seconds/minutes (60), hours (24) and centiseconds (100) stages.

## Interface
- `MODULUS`, default 60: count range is 0 to MODULUS-1. Legal values are 2 to 100.
- `clk` input 1: system clock. All state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clk_time` input 1: count tick, sampled synchronously. Normally a one-`clk` pulse. Held high, it counts on every cycle.
- `count_enable` input 1: gates `clk_time`. Ticks are ignored while low; load is unaffected.
- `load_enable` input 1: synchronous load of `set_value1`/`set_value10`.
- `set_value1` input 4: BCD ones digit to load.
- `set_value10` input 4: BCD tens digit to load.
- `inc1` output 4: BCD ones digit (registered).
- `inc10` output 4: BCD tens digit (registered).
- `inc_clk` output 1: carry pulse (registered). One `clk` cycle wide on wrap from MODULUS-1 to 0.
- `load_error` output 1: one-cycle pulse (registered) when a rejected load value is presented.

## Operation
- Reset (`reset_n` low, asynchronous): `inc1`=0, `inc10`=0, `inc_clk`=0, `load_error`=0. Holds while low. The counter resumes from 00 on the first edge after release.
- Priority per rising edge: load > tick > idle.
- Load (`load_enable`=1):
  - Value V = 10*`set_value10` + `set_value1`.
  - Valid if both digits are ≤9 and V < MODULUS. Then `inc1`/`inc10` take the set values and `load_error`=0.
  - Invalid: both digits load 0 and `load_error`=1 for that cycle.
  - `inc_clk`=0 on every load cycle, even when a tick arrives in the same cycle. That tick is dropped.
- Tick (`clk_time`=1 and `count_enable`=1, no load):
  - Wrap: if the current value equals MODULUS-1, the value becomes 00 and `inc_clk`=1.
  - Ones digit rolls over: else if `inc1`=9, `inc1` becomes 0, `inc10` increments by 1, and `inc_clk`=0.
  - Normal step: else `inc1` increments by 1 and `inc_clk`=0.
- Idle: value holds, `inc_clk`=0, `load_error`=0.
- Both pulses clear on the next edge unless re-triggered. No state machine beyond the counter registers.
- Arithmetic:
  - Pure BCD; each digit stays within 0 to 9 at all times.
  - Terminal count is compared as digits: tens = (MODULUS-1)/10, ones = (MODULUS-1)%10.
  - MODULUS=100 uses terminal 99. MODULUS<10 keeps `inc10` at 0.

## Timing
- Latency is one cycle for every event. A tick or load sampled at edge k is visible on the outputs after edge k.
- `inc_clk` is high for exactly the cycle between edges k and k+1 when a wrap occurs at edge k. With `clk_time` held high and MODULUS=2, it pulses every second cycle.
- Cascade delay: the next stage sees `inc_clk` at edge k+1. This one-`clk` skew per stage is accepted.
- Reset mid-pulse forces `inc_clk` and `load_error` low immediately, without waiting for a clock edge.
- A tick with `count_enable`=0 is lost, not queued.

## Test plan
- Reset release, MODULUS=60: assert `reset_n`=0 mid-count at 37, then release. Required: outputs read 0/0 with no clock edge; pulses are 0; the first tick after release gives 01.
- Wrap: load 58, then two ticks. Required: 59, then 00 with `inc_clk`=1 for exactly one cycle. A third tick gives 01 with `inc_clk`=0.
- Digit roll and hold: load 09, tick with `count_enable`=1 to get 10; tick again with `count_enable`=0. Required: value stays 10 and no pulse.
- Load vs tick collision: at value 59, `load_enable`=1 with 23 and `clk_time`=1 in the same cycle. Required: value 23, `inc_clk`=0.
- Invalid loads, MODULUS=24: load tens=2/ones=7 (27 ≥ 24), then tens=1/ones=12 (non-BCD). Required: each gives value 00 and a one-cycle `load_error`=1. A load of 23 is accepted, and a tick then wraps to 00 with `inc_clk`=1.
- MODULUS=100 with `clk_time` held high for 200 cycles from 00. Required: exactly 2 `inc_clk` pulses, 100 cycles apart. Every sample has both digits ≤9.
